// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch FSM state encoding
//   PCMUX_*       : PC unit mux selects; the fetch stage only ever requests increment
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        ERR
    } fetch_state_t;

    localparam logic [1:0] PCMUX_BUS  = 2'b00;
    localparam logic [1:0] PCMUX_ADDR = 2'b01;
    localparam logic [1:0] PCMUX_INC  = 2'b10;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Memory-wait counter for the fetch stage.
//   Clk, Reset_al : clock, async active-low reset
//   clr_i         : restart the count (to 0, or to 1 when en_i is also high)
//   en_i          : count one more wait cycle
//   tc_o          : count has reached MAX_WAIT
module fetch_timeout_ctr #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic Clk,
    input  logic Reset_al,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [7:0] cnt_q, cnt_d;

    // clr_i with en_i means "first wait cycle starts now", so the count lands on 1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = en_i ? 8'd1 : 8'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == MAX_WAIT[7:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: latches PC into MAR, reads memory, pulses the PC
// unit to increment, and hands the returned word to decode as IR.
//   Clk, Reset_al        : clock, async active-low reset
//   Run, PC_val, Redirect: fetch enable, current PC, branch/jump squash
//   LD_PC, PCMUX         : PC unit increment strobe and mux select
//   Mem_req/addr/rdy/rdata: variable-latency memory read port
//   IR, IR_valid, IR_ready: instruction handshake to decode
//   Fetch_busy, Fetch_err: status (not idle, sticky memory timeout)
//
// state | meaning
// IDLE  | waiting for Run without Redirect; MAR captures PC_val on exit
// ISSUE | first request cycle, PC increment strobe
// WAIT  | request held until Mem_rdy, bounded by MAX_WAIT
// HOLD  | IR presented to decode until accepted or redirected
// ERR   | memory timeout; left only through reset
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter logic [15:0] RESET_IR = 16'h0000
) (
    input  logic        Clk,
    input  logic        Reset_al,
    input  logic        Run,
    input  logic [15:0] PC_val,
    input  logic        Redirect,
    output logic        LD_PC,
    output logic [1:0]  PCMUX,
    output logic        Mem_req,
    output logic [15:0] Mem_addr,
    input  logic        Mem_rdy,
    input  logic [15:0] Mem_rdata,
    output logic [15:0] IR,
    output logic        IR_valid,
    input  logic        IR_ready,
    output logic        Fetch_busy,
    output logic        Fetch_err
);

    fetch_state_t state_q, state_d;
    logic [15:0]  mar_q, mar_d;
    logic [15:0]  ir_q, ir_d;
    logic         squash_q, squash_d;
    logic         ctr_clr, ctr_en, ctr_tc;

    fetch_timeout_ctr #(.MAX_WAIT(MAX_WAIT)) u_timeout (
        .Clk      (Clk),
        .Reset_al (Reset_al),
        .clr_i    (ctr_clr),
        .en_i     (ctr_en),
        .tc_o     (ctr_tc)
    );

    // The read data register doubles as IR: a word is only written when it will
    // be delivered, so squashed reads never disturb the instruction on display.
    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        ir_d     = ir_q;
        squash_d = squash_q;
        LD_PC    = 1'b0;
        Mem_req  = 1'b0;
        IR_valid = 1'b0;
        ctr_clr  = 1'b0;
        ctr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                ctr_clr = 1'b1;
                if (Run && !Redirect) begin
                    mar_d   = PC_val;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                Mem_req = 1'b1;
                LD_PC   = !Redirect;
                if (Redirect) squash_d = 1'b1;
                if (Mem_rdy) begin
                    squash_d = 1'b0;
                    if (squash_q || Redirect) begin
                        state_d = IDLE;
                    end else begin
                        ir_d    = Mem_rdata;
                        state_d = HOLD;
                    end
                end else begin
                    ctr_clr = 1'b1;
                    ctr_en  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                Mem_req = 1'b1;
                if (Redirect) squash_d = 1'b1;
                if (Mem_rdy) begin
                    squash_d = 1'b0;
                    if (squash_q || Redirect) begin
                        state_d = IDLE;
                    end else begin
                        ir_d    = Mem_rdata;
                        state_d = HOLD;
                    end
                end else if (ctr_tc) begin
                    state_d = ERR;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            HOLD: begin
                // Redirect masks the handshake combinationally so decode never
                // accepts a wrong-path instruction.
                IR_valid = !Redirect;
                if (Redirect || IR_ready) state_d = IDLE;
            end
            ERR: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            state_q  <= IDLE;
            mar_q    <= 16'h0000;
            ir_q     <= RESET_IR;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mar_q    <= mar_d;
            ir_q     <= ir_d;
            squash_q <= squash_d;
        end
    end

    assign PCMUX      = PCMUX_INC;
    assign Mem_addr   = mar_q;
    assign IR         = ir_q;
    assign Fetch_busy = (state_q != IDLE);
    assign Fetch_err  = (state_q == ERR);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          MAXW = 15;
    localparam logic [15:0] RIR  = 16'hC0DE;

    logic        Clk = 1'b0;
    logic        Reset_al = 1'b0;
    logic        Run = 1'b0;
    logic        Redirect = 1'b0;
    logic        IR_ready = 1'b0;
    logic        Mem_rdy = 1'b0;
    logic [15:0] Mem_rdata = 16'h0000;
    logic [15:0] PC_val;
    logic        LD_PC, Mem_req, IR_valid, Fetch_busy, Fetch_err;
    logic [1:0]  PCMUX;
    logic [15:0] Mem_addr, IR;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int ldpc_cnt = 0;
    int mem_lat = 0;
    int resp_n = 0;

    // Bench model of the PC unit.
    logic        pc_set = 1'b0;
    logic [15:0] pc_set_val = 16'h0000;
    logic [15:0] redir_val = 16'h0000;
    logic [15:0] pc = 16'h0000;
    assign PC_val = pc;

    always #5 Clk = ~Clk;

    fetch_unit #(.MAX_WAIT(MAXW), .RESET_IR(RIR)) dut (
        .Clk(Clk), .Reset_al(Reset_al), .Run(Run), .PC_val(PC_val),
        .Redirect(Redirect), .LD_PC(LD_PC), .PCMUX(PCMUX), .Mem_req(Mem_req),
        .Mem_addr(Mem_addr), .Mem_rdy(Mem_rdy), .Mem_rdata(Mem_rdata),
        .IR(IR), .IR_valid(IR_valid), .IR_ready(IR_ready),
        .Fetch_busy(Fetch_busy), .Fetch_err(Fetch_err)
    );

    function automatic logic [15:0] memf(input logic [15:0] a);
        if (a == 16'h3000) return 16'h1234;
        if (a == 16'h3001) return 16'h5678;
        return a ^ 16'hBEEF;
    endfunction

    always @(posedge Clk) begin
        if (pc_set) pc <= pc_set_val;
        else if (Redirect) pc <= redir_val;
        else if (LD_PC) pc <= pc + 16'd1;
    end

    // Memory responder: Mem_rdy in the (mem_lat+1)-th request cycle; -1 = never.
    always begin
        @(posedge Clk);
        #1;
        if (!Reset_al || !Mem_req) begin
            Mem_rdy = 1'b0;
            resp_n = 0;
        end else if (mem_lat >= 0 && resp_n >= mem_lat) begin
            Mem_rdy = 1'b1;
            Mem_rdata = memf(Mem_addr);
            resp_n = 0;
        end else begin
            Mem_rdy = 1'b0;
            Mem_rdata = 16'hDEAD;
            resp_n++;
        end
    end

    // Observed transfers and PC strobes.
    always @(negedge Clk) begin
        if (Reset_al === 1'b1 && IR_valid === 1'b1 && IR_ready === 1'b1) got_q.push_back(IR);
        if (LD_PC === 1'b1) ldpc_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic start_fetch(input logic [15:0] a);
        pc_set = 1'b1;
        pc_set_val = a;
        step(1);
        pc_set = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        total++; if (Mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", Mem_req); end
        total++; if (LD_PC !== 1'b0) begin bad++; $display("FAIL rst_ld_pc got=%b exp=0", LD_PC); end
        total++; if (IR_valid !== 1'b0) begin bad++; $display("FAIL rst_ir_valid got=%b exp=0", IR_valid); end
        total++; if (IR !== RIR) begin bad++; $display("FAIL rst_ir got=%h exp=%h", IR, RIR); end
        total++; if (Mem_addr !== 16'h0000) begin bad++; $display("FAIL rst_mar got=%h exp=0000", Mem_addr); end
        total++; if (Fetch_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", Fetch_busy); end
        total++; if (Fetch_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", Fetch_err); end
        total++; if (PCMUX !== 2'b10) begin bad++; $display("FAIL rst_pcmux got=%b exp=10", PCMUX); end
        Reset_al = 1'b1;
        start_fetch(16'h1000);
        step(3);
        total++; if (Fetch_busy !== 1'b0 || Mem_req !== 1'b0) begin
            bad++; $display("FAIL rst_no_resume got busy=%b req=%b exp=0/0", Fetch_busy, Mem_req);
        end
    endtask

    task automatic test_zero_wait();
        int c0;
        logic [15:0] e, g;
        mem_lat = 0;
        IR_ready = 1'b1;
        start_fetch(16'h3000);
        c0 = ldpc_cnt;
        exp_q.push_back(memf(16'h3000));
        exp_q.push_back(memf(16'h3001));
        Run = 1'b1;
        step(1);
        total++; if (Mem_req !== 1'b1 || Mem_addr !== 16'h3000 || LD_PC !== 1'b1) begin
            bad++; $display("FAIL zw_issue0 got req=%b addr=%h ld=%b exp=1/3000/1", Mem_req, Mem_addr, LD_PC);
        end
        step(1);
        total++; if (IR_valid !== 1'b1 || IR !== 16'h1234 || Mem_req !== 1'b0) begin
            bad++; $display("FAIL zw_hold0 got v=%b ir=%h req=%b exp=1/1234/0", IR_valid, IR, Mem_req);
        end
        step(1);
        total++; if (Fetch_busy !== 1'b0) begin bad++; $display("FAIL zw_idle got=%b exp=0", Fetch_busy); end
        step(1);
        Run = 1'b0;
        total++; if (Mem_req !== 1'b1 || Mem_addr !== 16'h3001 || LD_PC !== 1'b1) begin
            bad++; $display("FAIL zw_issue1 got req=%b addr=%h ld=%b exp=1/3001/1", Mem_req, Mem_addr, LD_PC);
        end
        step(1);
        total++; if (IR_valid !== 1'b1 || IR !== 16'h5678) begin
            bad++; $display("FAIL zw_hold1 got v=%b ir=%h exp=1/5678", IR_valid, IR);
        end
        step(3);
        total++; if (Fetch_busy !== 1'b0 || Mem_req !== 1'b0) begin
            bad++; $display("FAIL zw_stop got busy=%b req=%b exp=0/0", Fetch_busy, Mem_req);
        end
        total++; if (ldpc_cnt - c0 != 2) begin bad++; $display("FAIL zw_ldpc got=%0d exp=2", ldpc_cnt - c0); end
        total++; if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL zw_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL zw_sb got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_latency();
        int c0;
        logic [15:0] e, g;
        mem_lat = 2;
        IR_ready = 1'b1;
        start_fetch(16'h5000);
        c0 = ldpc_cnt;
        exp_q.push_back(memf(16'h5000));
        Run = 1'b1;
        step(1);
        Run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (Mem_req !== 1'b1 || Mem_addr !== 16'h5000 || LD_PC !== (i == 0)) begin
                bad++; $display("FAIL lat_req%0d got req=%b addr=%h ld=%b exp=1/5000/%0d", i, Mem_req, Mem_addr, LD_PC, i == 0);
            end
            step(1);
        end
        total++; if (IR_valid !== 1'b1 || IR !== memf(16'h5000)) begin
            bad++; $display("FAIL lat_hold got v=%b ir=%h exp=1/%h", IR_valid, IR, memf(16'h5000));
        end
        step(1);
        total++; if (Fetch_busy !== 1'b0) begin bad++; $display("FAIL lat_idle got=%b exp=0", Fetch_busy); end
        total++; if (ldpc_cnt - c0 != 1) begin bad++; $display("FAIL lat_ldpc got=%0d exp=1", ldpc_cnt - c0); end
        total++; if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL lat_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL lat_sb got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        logic [15:0] e, g;
        mem_lat = 0;
        IR_ready = 1'b0;
        start_fetch(16'h6000);
        exp_q.push_back(memf(16'h6000));
        Run = 1'b1;
        step(1);
        Run = 1'b0;
        step(1);
        for (int i = 0; i < 5; i++) begin
            total++; if (IR_valid !== 1'b1 || IR !== memf(16'h6000) || Mem_req !== 1'b0) begin
                bad++; $display("FAIL bp_stall%0d got v=%b ir=%h req=%b exp=1/%h/0", i, IR_valid, IR, Mem_req, memf(16'h6000));
            end
            if (i == 4) IR_ready = 1'b1;
            step(1);
        end
        total++; if (IR_valid !== 1'b0 || Fetch_busy !== 1'b0) begin
            bad++; $display("FAIL bp_release got v=%b busy=%b exp=0/0", IR_valid, Fetch_busy);
        end
        total++; if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL bp_sb got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_redirect();
        int n;
        mem_lat = 3;
        IR_ready = 1'b1;
        start_fetch(16'h7000);
        Run = 1'b1;
        step(1);
        Run = 1'b0;
        step(1);
        total++; if (Mem_req !== 1'b1 || LD_PC !== 1'b0) begin
            bad++; $display("FAIL rd_wait got req=%b ld=%b exp=1/0", Mem_req, LD_PC);
        end
        Redirect = 1'b1;
        redir_val = 16'h4000;
        step(1);
        Redirect = 1'b0;
        n = 0;
        while (Fetch_busy === 1'b1 && n < 10) begin step(1); n++; end
        total++; if (Fetch_busy !== 1'b0) begin bad++; $display("FAIL rd_wait_done got busy=%b exp=0", Fetch_busy); end
        total++; if (got_q.size() != 0) begin bad++; $display("FAIL rd_wait_drop got=%0d exp=0", got_q.size()); end
        Run = 1'b1;
        step(1);
        Run = 1'b0;
        total++; if (Mem_addr !== 16'h4000 || LD_PC !== 1'b1) begin
            bad++; $display("FAIL rd_refetch got addr=%h ld=%b exp=4000/1", Mem_addr, LD_PC);
        end
        n = 0;
        while (IR_valid !== 1'b1 && n < 10) begin step(1); n++; end
        total++; if (IR_valid !== 1'b1) begin bad++; $display("FAIL rd_hold_reach got v=%b exp=1", IR_valid); end
        Redirect = 1'b1;
        redir_val = 16'h4100;
        #1;
        total++; if (IR_valid !== 1'b0) begin bad++; $display("FAIL rd_hold_mask got v=%b exp=0", IR_valid); end
        step(1);
        Redirect = 1'b0;
        total++; if (Fetch_busy !== 1'b0 || got_q.size() != 0) begin
            bad++; $display("FAIL rd_hold_drop got busy=%b xfers=%0d exp=0/0", Fetch_busy, got_q.size());
        end
        mem_lat = 0;
        start_fetch(16'h7100);
        Run = 1'b1;
        step(1);
        Run = 1'b0;
        Redirect = 1'b1;
        redir_val = 16'h4200;
        #1;
        total++; if (LD_PC !== 1'b0 || Mem_req !== 1'b1) begin
            bad++; $display("FAIL rd_issue got ld=%b req=%b exp=0/1", LD_PC, Mem_req);
        end
        step(1);
        Redirect = 1'b0;
        total++; if (Fetch_busy !== 1'b0 || IR_valid !== 1'b0 || got_q.size() != 0) begin
            bad++; $display("FAIL rd_issue_drop got busy=%b v=%b xfers=%0d exp=0/0/0", Fetch_busy, IR_valid, got_q.size());
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_timeout();
        int errs;
        mem_lat = -1;
        start_fetch(16'h8000);
        Run = 1'b1;
        step(1);
        Run = 1'b0;
        total++; if (Mem_req !== 1'b1) begin bad++; $display("FAIL to_issue got req=%b exp=1", Mem_req); end
        errs = 0;
        for (int i = 0; i < MAXW; i++) begin
            step(1);
            if (Mem_req !== 1'b1 || Fetch_err !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL to_wait_cycles got bad_cycles=%0d exp=0", errs); end
        step(1);
        total++; if (Fetch_err !== 1'b1 || Mem_req !== 1'b0 || IR_valid !== 1'b0 || Fetch_busy !== 1'b1) begin
            bad++; $display("FAIL to_err got err=%b req=%b v=%b busy=%b exp=1/0/0/1", Fetch_err, Mem_req, IR_valid, Fetch_busy);
        end
        Run = 1'b1;
        step(5);
        total++; if (Fetch_err !== 1'b1 || Mem_req !== 1'b0 || LD_PC !== 1'b0) begin
            bad++; $display("FAIL to_sticky got err=%b req=%b ld=%b exp=1/0/0", Fetch_err, Mem_req, LD_PC);
        end
        Run = 1'b0;
        Reset_al = 1'b0;
        #1;
        total++; if (Fetch_err !== 1'b0) begin bad++; $display("FAIL to_reset_clear got=%b exp=0", Fetch_err); end
        step(1);
        Reset_al = 1'b1;
        step(1);
    endtask

    task automatic test_async_reset();
        logic [15:0] a, e, g;
        mem_lat = 10;
        IR_ready = 1'b1;
        start_fetch(16'h9000);
        Run = 1'b1;
        step(1);
        Run = 1'b0;
        step(2);
        total++; if (Mem_req !== 1'b1) begin bad++; $display("FAIL ar_in_wait got req=%b exp=1", Mem_req); end
        #1;
        Reset_al = 1'b0;
        #1;
        total++; if (Mem_req !== 1'b0 || IR_valid !== 1'b0 || IR !== RIR || Fetch_busy !== 1'b0) begin
            bad++; $display("FAIL ar_async got req=%b v=%b ir=%h busy=%b exp=0/0/%h/0", Mem_req, IR_valid, IR, Fetch_busy, RIR);
        end
        step(2);
        Reset_al = 1'b1;
        mem_lat = 0;
        step(3);
        total++; if (Mem_req !== 1'b0 || Fetch_busy !== 1'b0) begin
            bad++; $display("FAIL ar_no_resume got req=%b busy=%b exp=0/0", Mem_req, Fetch_busy);
        end
        a = pc;
        exp_q.push_back(memf(a));
        Run = 1'b1;
        step(1);
        Run = 1'b0;
        total++; if (Mem_req !== 1'b1 || Mem_addr !== a) begin
            bad++; $display("FAIL ar_restart got req=%b addr=%h exp=1/%h", Mem_req, Mem_addr, a);
        end
        step(1);
        total++; if (IR_valid !== 1'b1 || IR !== memf(a)) begin
            bad++; $display("FAIL ar_hold got v=%b ir=%h exp=1/%h", IR_valid, IR, memf(a));
        end
        step(2);
        total++; if (got_q.size() != exp_q.size()) begin
            bad++; $display("FAIL ar_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL ar_sb got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_backpressure();
        test_redirect();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
